// File: rtl/rv_structs.sv
// Shared types and constants for the RV memory stage.
// Holds the memory-stage FSM state type, the funct3 access-size
// encodings, and a helper that detects misaligned accesses.
package rv_structs;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // funct3 encodings for loads/stores (stores use the B/H/W codes)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halfwords must sit on even addresses, words on multiples of four.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic res;
    case (funct3[1:0])
      2'b01:   res = addr_lo[0];
      2'b10:   res = (addr_lo != 2'b00);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rv_load_align.sv
// Load data lane extraction and sign/zero extension.
// Byte lane is selected by addr[1:0], halfword lane by addr[1].
module rv_load_align
  import rv_structs::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword out of the bus word
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    case (i_addr_lo)
      2'b00:   w_byte = i_rdata[7:0];
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      2'b11:   w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
  end

  // Extend the selected lane according to the access size/sign
  always_comb begin
    o_data = 32'h0000_0000;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_data = i_rdata;
      F3_BU:   o_data = {24'h00_0000, w_byte};
      F3_HU:   o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/rv_mem_stage.sv
// RV pipeline memory stage: registers one instruction from the ALU,
// runs a data-bus access for loads/stores, and presents writeback.
// Optional build macro RV_MISALIGN_TRAP_EN turns misaligned halfword/word
// accesses into single-cycle traps and adds the o_misalign output.
module rv_mem_stage
  import rv_structs::*;
#(
  parameter int unsigned IADDR_SPACE_BITS = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_flush,
  input  logic                        i_valid,
  input  logic [31:0]                 i_result,
  input  logic [31:0]                 i_add,
  input  logic                        i_load,
  input  logic                        i_store,
  input  logic                        i_reg_write,
  input  logic [4:0]                  i_rd,
  input  logic [31:0]                 i_wdata,
  input  logic [3:0]                  i_wsel,
  input  logic [2:0]                  i_funct3,
  input  logic                        i_to_trap,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc,
  input  logic                        i_dbus_ack,
  input  logic [31:0]                 i_dbus_rdata,
  output logic                        o_dbus_req,
  output logic                        o_dbus_we,
  output logic [31:0]                 o_dbus_addr,
  output logic [31:0]                 o_dbus_wdata,
  output logic [3:0]                  o_dbus_wsel,
  output logic                        o_wb_valid,
  output logic                        o_reg_write,
  output logic [4:0]                  o_rd,
  output logic [31:0]                 o_wb_data,
  output logic [IADDR_SPACE_BITS-1:0] o_pc,
  output logic                        o_to_trap,
  output logic                        o_ready
`ifdef RV_MISALIGN_TRAP_EN
  ,
  output logic                        o_misalign
`endif
);

  mem_state_t                  r_state;
  mem_state_t                  w_state_next;
  logic                        r_dbus_req;
  logic                        r_dbus_we;
  logic [31:0]                 r_dbus_addr;
  logic [31:0]                 r_dbus_wdata;
  logic [3:0]                  r_dbus_wsel;
  logic                        r_wb_valid;
  logic                        r_reg_write;
  logic [4:0]                  r_rd;
  logic [31:0]                 r_wb_data;
  logic [IADDR_SPACE_BITS-1:0] r_pc;
  logic                        r_to_trap;
  logic [2:0]                  r_funct3;
  logic [1:0]                  r_addr_lo;
  logic                        r_flush_pend;

  logic        w_accept;
  logic        w_misalign;
  logic        w_is_mem;
  logic [31:0] w_load_data;

  assign w_accept = i_valid & (r_state == IDLE) & ~i_flush;

`ifdef RV_MISALIGN_TRAP_EN
  assign w_misalign = (i_load | i_store) & is_misaligned(i_funct3, i_add[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  // Trapping or misaligned instructions never reach the bus
  assign w_is_mem = (i_load | i_store) & ~i_to_trap & ~w_misalign;

  rv_load_align u_load_align (
    .i_rdata   (i_dbus_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_data    (w_load_data)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: enter ACCESS on an accepted memory op, leave on ack
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mem) begin
          w_state_next = ACCESS;
        end else begin
          w_state_next = IDLE;
        end
      end
      ACCESS: begin
        if (i_dbus_ack) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = ACCESS;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: capture accepted instruction, drive bus, produce writeback
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_dbus_req   <= 1'b0;
      r_dbus_we    <= 1'b0;
      r_dbus_addr  <= 32'h0000_0000;
      r_dbus_wdata <= 32'h0000_0000;
      r_dbus_wsel  <= 4'h0;
      r_wb_valid   <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= 5'd0;
      r_wb_data    <= 32'h0000_0000;
      r_pc         <= '0;
      r_to_trap    <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_flush_pend <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rd      <= i_rd;
            r_pc      <= i_pc;
            r_to_trap <= i_to_trap | w_misalign;
            if (w_is_mem) begin
              r_dbus_req   <= 1'b1;
              r_dbus_we    <= i_store;
              r_dbus_addr  <= {i_add[31:2], 2'b00};
              r_dbus_wdata <= i_wdata;
              r_dbus_wsel  <= i_wsel;
              r_reg_write  <= i_reg_write & ~i_store;
              r_funct3     <= i_funct3;
              r_addr_lo    <= i_add[1:0];
              r_flush_pend <= 1'b0;
            end else begin
              r_wb_valid  <= 1'b1;
              r_wb_data   <= i_result;
              r_reg_write <= i_reg_write & ~w_misalign;
            end
          end
        end
        ACCESS: begin
          if (i_flush) begin
            r_flush_pend <= 1'b1;
          end
          if (i_dbus_ack) begin
            r_dbus_req   <= 1'b0;
            r_dbus_we    <= 1'b0;
            r_wb_valid   <= ~(r_flush_pend | i_flush);
            r_flush_pend <= 1'b0;
            if (!r_dbus_we) begin
              r_wb_data <= w_load_data;
            end
          end
        end
        default: r_dbus_req <= 1'b0;
      endcase
    end
  end

`ifdef RV_MISALIGN_TRAP_EN
  logic r_misalign;

  // Misalignment flag, presented alongside its writeback pulse
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_misalign <= 1'b0;
    end else if (r_state == IDLE) begin
      r_misalign <= w_accept & w_misalign;
    end else begin
      r_misalign <= 1'b0;
    end
  end

  assign o_misalign = r_misalign;
`endif

  assign o_ready      = (r_state == IDLE);
  assign o_dbus_req   = r_dbus_req;
  assign o_dbus_we    = r_dbus_we;
  assign o_dbus_addr  = r_dbus_addr;
  assign o_dbus_wdata = r_dbus_wdata;
  assign o_dbus_wsel  = r_dbus_wsel;
  assign o_wb_valid   = r_wb_valid;
  assign o_reg_write  = r_reg_write;
  assign o_rd         = r_rd;
  assign o_wb_data    = r_wb_data;
  assign o_pc         = r_pc;
  assign o_to_trap    = r_to_trap;

endmodule

// File: tb/tb_rv_mem_stage.sv
// Directed self-checking bench for rv_mem_stage.
module tb_rv_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_flush;
  logic        i_valid;
  logic [31:0] i_result;
  logic [31:0] i_add;
  logic        i_load;
  logic        i_store;
  logic        i_reg_write;
  logic [4:0]  i_rd;
  logic [31:0] i_wdata;
  logic [3:0]  i_wsel;
  logic [2:0]  i_funct3;
  logic        i_to_trap;
  logic [31:0] i_pc;
  logic        i_dbus_ack;
  logic [31:0] i_dbus_rdata;
  logic        o_dbus_req;
  logic        o_dbus_we;
  logic [31:0] o_dbus_addr;
  logic [31:0] o_dbus_wdata;
  logic [3:0]  o_dbus_wsel;
  logic        o_wb_valid;
  logic        o_reg_write;
  logic [4:0]  o_rd;
  logic [31:0] o_wb_data;
  logic [31:0] o_pc;
  logic        o_to_trap;
  logic        o_ready;
`ifdef RV_MISALIGN_TRAP_EN
  logic        o_misalign;
`endif

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  rv_mem_stage #(.IADDR_SPACE_BITS(32)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_valid(i_valid),
    .i_result(i_result), .i_add(i_add), .i_load(i_load), .i_store(i_store),
    .i_reg_write(i_reg_write), .i_rd(i_rd), .i_wdata(i_wdata), .i_wsel(i_wsel),
    .i_funct3(i_funct3), .i_to_trap(i_to_trap), .i_pc(i_pc),
    .i_dbus_ack(i_dbus_ack), .i_dbus_rdata(i_dbus_rdata),
    .o_dbus_req(o_dbus_req), .o_dbus_we(o_dbus_we), .o_dbus_addr(o_dbus_addr),
    .o_dbus_wdata(o_dbus_wdata), .o_dbus_wsel(o_dbus_wsel),
    .o_wb_valid(o_wb_valid), .o_reg_write(o_reg_write), .o_rd(o_rd),
    .o_wb_data(o_wb_data), .o_pc(o_pc), .o_to_trap(o_to_trap), .o_ready(o_ready)
`ifdef RV_MISALIGN_TRAP_EN
    , .o_misalign(o_misalign)
`endif
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_flush = 1'b0; i_valid = 1'b0; i_result = 32'h0; i_add = 32'h0;
    i_load = 1'b0; i_store = 1'b0; i_reg_write = 1'b0; i_rd = 5'd0;
    i_wdata = 32'h0; i_wsel = 4'h0; i_funct3 = 3'b000; i_to_trap = 1'b0;
    i_pc = 32'h0; i_dbus_ack = 1'b0; i_dbus_rdata = 32'h0;
  endtask

  // Present one instruction for a single cycle
  task automatic issue(input logic ld, input logic st, input logic rw, input logic trap,
                       input logic [2:0] f3, input logic [31:0] add, input logic [31:0] res,
                       input logic [31:0] wd, input logic [3:0] ws, input logic [4:0] rd,
                       input logic [31:0] pc);
    i_valid = 1'b1; i_load = ld; i_store = st; i_reg_write = rw; i_to_trap = trap;
    i_funct3 = f3; i_add = add; i_result = res; i_wdata = wd; i_wsel = ws;
    i_rd = rd; i_pc = pc;
    tick();
    i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0; i_reg_write = 1'b0; i_to_trap = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_reset_n = 1'b0;
    tick(); tick();
    checks++;
    if ({o_dbus_req, o_dbus_we, o_wb_valid, o_reg_write, o_to_trap, o_ready} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000001",
               {o_dbus_req, o_dbus_we, o_wb_valid, o_reg_write, o_to_trap, o_ready});
    end
    checks++;
    if ({o_rd, o_wb_data, o_pc, o_dbus_addr, o_dbus_wdata, o_dbus_wsel} !== 137'd0) begin
      failures++;
      $display("FAIL reset_data rd=%h data=%h pc=%h addr=%h wdata=%h wsel=%h exp all zero",
               o_rd, o_wb_data, o_pc, o_dbus_addr, o_dbus_wdata, o_dbus_wsel);
    end
    i_reset_n = 1'b1;
  endtask

  task automatic test_alu_back_to_back();
    issue(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h1234_5678, 32'h0, 4'h0, 5'd7, 32'h0000_0080);
    checks++;
    if ({o_wb_valid, o_reg_write, o_rd, o_wb_data, o_pc, o_ready, o_dbus_req} !==
        {1'b1, 1'b1, 5'd7, 32'h1234_5678, 32'h0000_0080, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL alu1 got v=%b rw=%b rd=%0d d=%h pc=%h rdy=%b req=%b exp 1 1 7 12345678 00000080 1 0",
               o_wb_valid, o_reg_write, o_rd, o_wb_data, o_pc, o_ready, o_dbus_req);
    end
    issue(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'hCAFE_0001, 32'h0, 4'h0, 5'd9, 32'h0000_0084);
    checks++;
    if ({o_wb_valid, o_reg_write, o_rd, o_wb_data} !== {1'b1, 1'b0, 5'd9, 32'hCAFE_0001}) begin
      failures++;
      $display("FAIL alu2 got v=%b rw=%b rd=%0d d=%h exp 1 0 9 cafe0001",
               o_wb_valid, o_reg_write, o_rd, o_wb_data);
    end
    tick();
    checks++;
    if (o_wb_valid !== 1'b0) begin
      failures++; $display("FAIL alu_pulse got=%b exp=0", o_wb_valid);
    end
  endtask

  task automatic test_lb_wait();
    issue(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h0, 4'h0, 5'd3, 32'h100);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({o_dbus_req, o_dbus_we, o_dbus_addr, o_wb_valid, o_ready} !== {1'b1, 1'b0, 32'h0000_1000, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL lb_req cyc=%0d got req=%b we=%b addr=%h v=%b rdy=%b exp 1 0 00001000 0 0",
                 c, o_dbus_req, o_dbus_we, o_dbus_addr, o_wb_valid, o_ready);
      end
      if (c == 2) begin
        i_dbus_ack = 1'b1; i_dbus_rdata = 32'h80FF_FF7F;
      end
      tick();
    end
    i_dbus_ack = 1'b0;
    checks++;
    if ({o_dbus_req, o_wb_valid, o_reg_write, o_rd, o_wb_data, o_ready} !==
        {1'b0, 1'b1, 1'b1, 5'd3, 32'hFFFF_FF80, 1'b1}) begin
      failures++;
      $display("FAIL lb_wb got req=%b v=%b rw=%b rd=%0d d=%h rdy=%b exp 0 1 1 3 ffffff80 1",
               o_dbus_req, o_wb_valid, o_reg_write, o_rd, o_wb_data, o_ready);
    end
    tick();
    checks++;
    if (o_wb_valid !== 1'b0) begin
      failures++; $display("FAIL lb_pulse got=%b exp=0", o_wb_valid);
    end
  endtask

  // Load with ack in the first access cycle; returns writeback data
  task automatic load_imm(input logic [2:0] f3, input logic [31:0] add, input logic [31:0] rdata,
                          output logic req_seen, output logic [31:0] data, output logic valid);
    issue(1'b1, 1'b0, 1'b1, 1'b0, f3, add, 32'h0, 32'h0, 4'h0, 5'd5, 32'h200);
    req_seen = o_dbus_req;
    i_dbus_ack = 1'b1; i_dbus_rdata = rdata;
    tick();
    i_dbus_ack = 1'b0;
    data = o_wb_data; valid = o_wb_valid;
  endtask

  task automatic test_loads();
    logic        rq;
    logic        v;
    logic [31:0] d;
    load_imm(3'b101, 32'h0000_2002, 32'hBEEF_1234, rq, d, v);
    checks++;
    if ({rq, v, d} !== {1'b1, 1'b1, 32'h0000_BEEF}) begin
      failures++; $display("FAIL lhu got req=%b v=%b d=%h exp 1 1 0000beef", rq, v, d);
    end
    load_imm(3'b001, 32'h0000_7002, 32'h8001_0000, rq, d, v);
    checks++;
    if ({v, d} !== {1'b1, 32'hFFFF_8001}) begin
      failures++; $display("FAIL lh got v=%b d=%h exp 1 ffff8001", v, d);
    end
    load_imm(3'b100, 32'h0000_7001, 32'h0000_9A00, rq, d, v);
    checks++;
    if ({v, d} !== {1'b1, 32'h0000_009A}) begin
      failures++; $display("FAIL lbu got v=%b d=%h exp 1 0000009a", v, d);
    end
    load_imm(3'b001, 32'h0000_7000, 32'h1234_F00D, rq, d, v);
    checks++;
    if ({v, d} !== {1'b1, 32'hFFFF_F00D}) begin
      failures++; $display("FAIL lh_lo got v=%b d=%h exp 1 fffff00d", v, d);
    end
  endtask

  task automatic test_sb();
    issue(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_3001, 32'h0, 32'hAAAA_AAAA, 4'b0010, 5'd0, 32'h300);
    checks++;
    if ({o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_wdata, o_dbus_wsel} !==
        {1'b1, 1'b1, 32'h0000_3000, 32'hAAAA_AAAA, 4'b0010}) begin
      failures++;
      $display("FAIL sb_bus got req=%b we=%b addr=%h wd=%h ws=%b exp 1 1 00003000 aaaaaaaa 0010",
               o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_wdata, o_dbus_wsel);
    end
    i_dbus_ack = 1'b1;
    tick();
    i_dbus_ack = 1'b0;
    checks++;
    if ({o_dbus_req, o_wb_valid, o_reg_write} !== 3'b010) begin
      failures++;
      $display("FAIL sb_wb got req=%b v=%b rw=%b exp 0 1 0", o_dbus_req, o_wb_valid, o_reg_write);
    end
  endtask

  task automatic test_flush_access();
    issue(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 4'h0, 5'd4, 32'h400);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    tick();
    checks++;
    if ({o_dbus_req, o_wb_valid} !== 2'b10) begin
      failures++; $display("FAIL flush_hold got req=%b v=%b exp 1 0", o_dbus_req, o_wb_valid);
    end
    i_dbus_ack = 1'b1; i_dbus_rdata = 32'h5555_5555;
    tick();
    i_dbus_ack = 1'b0;
    checks++;
    if ({o_dbus_req, o_wb_valid, o_ready} !== 3'b001) begin
      failures++;
      $display("FAIL flush_ack got req=%b v=%b rdy=%b exp 0 0 1", o_dbus_req, o_wb_valid, o_ready);
    end
  endtask

  task automatic test_flush_idle_ack_idle();
    issue(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h1111_1111, 32'h0, 4'h0, 5'd1, 32'h500);
    i_flush = 1'b1;
    issue(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h2222_2222, 32'h0, 4'h0, 5'd2, 32'h504);
    i_flush = 1'b0;
    checks++;
    if ({o_wb_valid, o_ready} !== 2'b01) begin
      failures++; $display("FAIL flush_idle got v=%b rdy=%b exp 0 1", o_wb_valid, o_ready);
    end
    i_dbus_ack = 1'b1; i_dbus_rdata = 32'hDEAD_BEEF;
    tick();
    i_dbus_ack = 1'b0;
    checks++;
    if ({o_wb_valid, o_dbus_req, o_ready} !== 3'b001) begin
      failures++;
      $display("FAIL ack_idle got v=%b req=%b rdy=%b exp 0 0 1", o_wb_valid, o_dbus_req, o_ready);
    end
  endtask

  task automatic test_trap();
    issue(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_6000, 32'h0000_6000, 32'h0, 4'h0, 5'd6, 32'h600);
    checks++;
    if ({o_dbus_req, o_wb_valid, o_to_trap, o_ready, o_wb_data} !== {4'b0111, 32'h0000_6000}) begin
      failures++;
      $display("FAIL trap got req=%b v=%b trap=%b rdy=%b d=%h exp 0 1 1 1 00006000",
               o_dbus_req, o_wb_valid, o_to_trap, o_ready, o_wb_data);
    end
  endtask

  task automatic test_misalign();
    issue(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_4002, 32'h0, 32'h0, 4'h0, 5'd8, 32'h700);
`ifdef RV_MISALIGN_TRAP_EN
    checks++;
    if ({o_dbus_req, o_misalign, o_to_trap, o_wb_valid, o_reg_write, o_ready} !== 6'b011101) begin
      failures++;
      $display("FAIL misalign_trap got req=%b mis=%b trap=%b v=%b rw=%b rdy=%b exp 0 1 1 1 0 1",
               o_dbus_req, o_misalign, o_to_trap, o_wb_valid, o_reg_write, o_ready);
    end
`else
    checks++;
    if ({o_dbus_req, o_dbus_addr} !== {1'b1, 32'h0000_4000}) begin
      failures++;
      $display("FAIL misalign_req got req=%b addr=%h exp 1 00004000", o_dbus_req, o_dbus_addr);
    end
    i_dbus_ack = 1'b1; i_dbus_rdata = 32'h1122_3344;
    tick();
    i_dbus_ack = 1'b0;
    checks++;
    if ({o_wb_valid, o_wb_data, o_to_trap} !== {1'b1, 32'h1122_3344, 1'b0}) begin
      failures++;
      $display("FAIL misalign_lw got v=%b d=%h trap=%b exp 1 11223344 0", o_wb_valid, o_wb_data, o_to_trap);
    end
`endif
  endtask

  task automatic test_reset_access();
    issue(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'h0, 32'h0, 4'h0, 5'd10, 32'h800);
    checks++;
    if (o_dbus_req !== 1'b1) begin
      failures++; $display("FAIL rst_acc_pre got req=%b exp 1", o_dbus_req);
    end
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    checks++;
    if ({o_dbus_req, o_ready, o_wb_valid} !== 3'b010) begin
      failures++;
      $display("FAIL rst_acc got req=%b rdy=%b v=%b exp 0 1 0", o_dbus_req, o_ready, o_wb_valid);
    end
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_lb_wait();
    test_loads();
    test_sb();
    test_flush_access();
    test_flush_idle_ack_idle();
    test_trap();
    test_misalign();
    test_reset_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_mem_stage.md
RV_MEM_STAGE -- requirements
Module: rv_mem_stage

Interface
REQ-001 Parameter: IADDR_SPACE_BITS, 32, width of the carried PC field.
REQ-002 Ports, clock and reset first: i_clk  in  1  sole clock; i_reset_n  in  1  reset, synchronous and active-low.
REQ-003 i_flush  in  1  kill the current and accepted instruction.
REQ-004 i_valid  in  1  upstream ALU holds a valid instruction (its ready is high).
REQ-005 i_result  in  32  ALU result.
REQ-006 i_add  in  32  effective address.
REQ-007 i_load  in  1  load instruction.
REQ-008 i_store  in  1  store instruction.
REQ-009 i_reg_write  in  1  register write enable.
REQ-010 i_rd  in  5  destination register.
REQ-011 i_wdata  in  32  lane-replicated store data.
REQ-012 i_wsel  in  4  byte-enable mask.
REQ-013 i_funct3  in  3  access size and sign.
REQ-014 i_to_trap  in  1  upstream trap flag.
REQ-015 i_pc  in  IADDR_SPACE_BITS  instruction PC.
REQ-016 Data bus inputs: i_dbus_ack  in  1  bus completion; i_dbus_rdata  in  32  read data, valid with ack.
REQ-017 Data bus outputs: o_dbus_req  out  1  request; o_dbus_we  out  1  write; o_dbus_addr  out  32  word-aligned address; o_dbus_wdata  out  32  write data; o_dbus_wsel  out  4  byte enables.
REQ-018 Writeback outputs: o_wb_valid  out  1  writeback valid; o_reg_write  out  1  register write; o_rd  out  5  destination; o_wb_data  out  32  writeback data.
REQ-019 Status outputs: o_pc  out  IADDR_SPACE_BITS  PC; o_to_trap  out  1  trap; o_ready  out  1  stage can accept.

Function
REQ-020 States are IDLE and ACCESS; o_ready SHALL equal (state==IDLE).
REQ-021 Accept SHALL occur on i_valid & o_ready & !i_flush, registering all fields.
REQ-022 A non-memory op SHALL present o_wb_valid=1 and o_wb_data=i_result in the cycle after accept, with state remaining IDLE.
REQ-023 A load or store SHALL move IDLE->ACCESS, with o_dbus_req=1 in the next cycle.
REQ-024 In ACCESS, o_dbus_addr={add[31:2],2'b00}, o_dbus_we=store, and wdata/wsel SHALL stay stable until ack.
REQ-025 ACCESS & i_dbus_ack SHALL deassert req in the next cycle, return to IDLE, and pulse o_wb_valid for one cycle.
REQ-026 Load data, by funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Byte lane is addr[1:0], halfword lane is addr[1]. Signed forms sign-extend; U forms zero-extend.
REQ-027 A store SHALL produce o_wb_valid=1 with o_reg_write=0.
REQ-028 Minimum latency: 1 cycle for non-memory ops; an access with same-cycle ack SHALL complete in 2 cycles.
REQ-029 i_flush in IDLE SHALL block accept and force o_wb_valid=0 in the next cycle.
REQ-030 i_flush in ACCESS SHALL hold req until ack, since in-flight bus cycles are not cancelled, and SHALL suppress that writeback (o_wb_valid=0).
REQ-031 Ack arriving in IDLE SHALL be ignored.
REQ-032 o_to_trap SHALL be the registered i_to_trap, valid with o_wb_valid.
REQ-033 A trapping instruction SHALL NOT issue a bus request and SHALL complete as a non-memory op.

Reset
REQ-034 On !i_reset_n at a clock edge: state=IDLE and o_dbus_req, o_dbus_we, o_wb_valid, o_reg_write, o_to_trap=0.
REQ-035 On reset, o_rd=0, o_wb_data=0, o_pc=0 and o_dbus_addr/wdata/wsel=0.
REQ-036 Reset during ACCESS SHALL abandon the transaction, with req low the next cycle.

Configuration
REQ-037 Macro RV_MISALIGN_TRAP_EN defined: an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]!=0, SHALL NOT issue a request, SHALL complete in 1 cycle with o_to_trap=1 and o_reg_write=0, and SHALL assert o_misalign (out, 1).
REQ-038 Macro RV_MISALIGN_TRAP_EN undefined: misaligned accesses SHALL issue normally per REQ-024/026 (low address bits dropped), and no o_misalign port SHALL exist.

Structure
REQ-039 mem_state_t (IDLE/ACCESS) and the funct3 load/store size constants SHALL live in the shared rv_structs package.
REQ-040 Load lane extraction and extension SHALL be a combinational sub-module rv_load_align (i_rdata, i_addr_lo, i_funct3 -> o_data).

Verification
REQ-041 LB with addr=0x1003, rdata=0x80FF_FF7F, ack after 2 wait cycles -> req high 3 cycles, then o_wb_data=0xFFFF_FF80, o_wb_valid=1 for one cycle.
REQ-042 LHU with addr=0x2002, rdata=0xBEEF_1234, immediate ack -> o_wb_data=0x0000_BEEF, completion in 2 cycles.
REQ-043 SB with addr=0x3001, wdata=0xAAAA_AAAA, wsel=0010 -> o_dbus_we=1, addr=0x3000, wsel=0010, then o_wb_valid=1 with o_reg_write=0.
REQ-044 Flush while in ACCESS, ack 3 cycles later -> req held until ack, o_wb_valid stays 0, state returns to IDLE.
REQ-045 With RV_MISALIGN_TRAP_EN, LW at addr=0x4002 -> no req, o_misalign=1 and o_to_trap=1 after 1 cycle.
REQ-046 Reset asserted during ACCESS -> req=0, state=IDLE, o_ready=1 after the next edge.
